// File: rtl/piso_serializer.sv
// Parallel-in serial-out converter with first/last framing strobes.
// Optional idle gap bits between words; all serial outputs registered.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter int CLK_DIV   = 4,
    parameter int MSB_FIRST = 1,
    parameter int GAP_BITS  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_data,
    output logic             ser_valid,
    output logic             ser_first,
    output logic             ser_last,
    output logic             busy
);

    localparam int BW      = $clog2(WIDTH);
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_LEN = GAP_BITS * CLK_DIV;
    localparam int GW      = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;

    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [DW-1:0]    div_q, div_d;
    logic [GW-1:0]    gap_q, gap_d;

    logic ser_data_q, ser_data_d;
    logic ser_valid_q, ser_valid_d;
    logic ser_first_q, ser_first_d;
    logic ser_last_q, ser_last_d;
    logic busy_q, busy_d;

    logic [WIDTH-1:0] sr_shifted;

    assign sr_shifted = (MSB_FIRST != 0) ? {sr_q[WIDTH-2:0], 1'b0}
                                         : {1'b0, sr_q[WIDTH-1:1]};

    // Next-state, counter and handshake logic; outputs derive from next state.
    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        bit_d    = bit_q;
        div_d    = div_q;
        gap_d    = gap_q;
        in_ready = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    sr_d    = in_data;
                    bit_d   = '0;
                    div_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (bit_q == BIT_LAST) begin
                        bit_d = '0;
                        if (GAP_BITS > 0) begin
                            gap_d   = '0;
                            state_d = GAP;
                        end else begin
                            in_ready = 1'b1;
                            if (in_valid) begin
                                sr_d = in_data;
                            end else begin
                                state_d = IDLE;
                            end
                        end
                    end else begin
                        bit_d = bit_q + BW'(1);
                        sr_d  = sr_shifted;
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (rst) begin
            in_ready = 1'b0;
            state_d  = IDLE;
            sr_d     = '0;
            bit_d    = '0;
            div_d    = '0;
            gap_d    = '0;
        end
    end

    // Registered outputs follow the state being entered.
    always_comb begin
        ser_data_d  = 1'b0;
        ser_valid_d = 1'b0;
        ser_first_d = 1'b0;
        ser_last_d  = 1'b0;
        busy_d      = (state_d != IDLE);
        if (state_d == SHIFT) begin
            ser_data_d  = (MSB_FIRST != 0) ? sr_d[WIDTH-1] : sr_d[0];
            ser_valid_d = 1'b1;
            ser_first_d = (bit_d == '0);
            ser_last_d  = (bit_d == BIT_LAST);
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            bit_q       <= '0;
            div_q       <= '0;
            gap_q       <= '0;
            ser_data_q  <= 1'b0;
            ser_valid_q <= 1'b0;
            ser_first_q <= 1'b0;
            ser_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            bit_q       <= bit_d;
            div_q       <= div_d;
            gap_q       <= gap_d;
            ser_data_q  <= ser_data_d;
            ser_valid_q <= ser_valid_d;
            ser_first_q <= ser_first_d;
            ser_last_q  <= ser_last_d;
            busy_q      <= busy_d;
        end
    end

    assign ser_data  = ser_data_q;
    assign ser_valid = ser_valid_q;
    assign ser_first = ser_first_q;
    assign ser_last  = ser_last_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer across three configurations.
// Inputs change 1 time unit after the rising edge; outputs checked there.
module tb_piso_serializer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // A: W8 D1 MSB-first no gap
    logic [7:0] a_data = '0;
    logic a_valid = 1'b0;
    logic a_ready, a_sd, a_sv, a_sf, a_sl, a_busy;
    // B: W8 D4 LSB-first no gap
    logic [7:0] b_data = '0;
    logic b_valid = 1'b0;
    logic b_ready, b_sd, b_sv, b_sf, b_sl, b_busy;
    // C: W8 D2 MSB-first gap 2
    logic [7:0] c_data = '0;
    logic c_valid = 1'b0;
    logic c_ready, c_sd, c_sv, c_sf, c_sl, c_busy;

    piso_serializer #(.WIDTH(8), .CLK_DIV(1), .MSB_FIRST(1), .GAP_BITS(0)) u_a (
        .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_valid),
        .in_ready(a_ready), .ser_data(a_sd), .ser_valid(a_sv),
        .ser_first(a_sf), .ser_last(a_sl), .busy(a_busy));

    piso_serializer #(.WIDTH(8), .CLK_DIV(4), .MSB_FIRST(0), .GAP_BITS(0)) u_b (
        .clk(clk), .rst(rst), .in_data(b_data), .in_valid(b_valid),
        .in_ready(b_ready), .ser_data(b_sd), .ser_valid(b_sv),
        .ser_first(b_sf), .ser_last(b_sl), .busy(b_busy));

    piso_serializer #(.WIDTH(8), .CLK_DIV(2), .MSB_FIRST(1), .GAP_BITS(2)) u_c (
        .clk(clk), .rst(rst), .in_data(c_data), .in_valid(c_valid),
        .in_ready(c_ready), .ser_data(c_sd), .ser_valid(c_sv),
        .ser_first(c_sf), .ser_last(c_sl), .busy(c_busy));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({a_sd, a_sv, a_sf, a_sl, a_busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outs got %b want 00000", {a_sd, a_sv, a_sf, a_sl, a_busy});
        end
        checks++;
        if ({a_ready, b_ready, c_ready} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ready got %b want 000", {a_ready, b_ready, c_ready});
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({a_ready, b_ready, c_ready} !== 3'b111) begin
            errors++;
            $display("FAIL reset_idle_ready got %b want 111", {a_ready, b_ready, c_ready});
        end
    endtask

    // 0xA5 at CLK_DIV=1: bits 1,0,1,0,0,1,0,1 on cycles 1-8.
    task automatic test_single_word();
        logic [7:0] exp_bits;
        exp_bits = 8'b1010_0101;
        a_data = 8'hA5;
        a_valid = 1'b1;
        checks++;
        if (a_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_ready0 got %b want 1", a_ready);
        end
        tick();
        a_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            checks++;
            if ({a_sv, a_sd, a_sf, a_sl, a_busy} !==
                {1'b1, exp_bits[8-c], (c == 1), (c == 8), 1'b1}) begin
                errors++;
                $display("FAIL single_c%0d got v/d/f/l/b %b want %b", c,
                         {a_sv, a_sd, a_sf, a_sl, a_busy},
                         {1'b1, exp_bits[8-c], (c == 1), (c == 8), 1'b1});
            end
            tick();
        end
        checks++;
        if ({a_sv, a_busy, a_ready} !== 3'b001) begin
            errors++;
            $display("FAIL single_idle got v/b/r %b want 001", {a_sv, a_busy, a_ready});
        end
    endtask

    // 0xA5 then 0x3C with in_valid held: 16 contiguous bit cycles.
    task automatic test_back_to_back();
        logic [15:0] exp_bits;
        exp_bits = 16'b1010_0101_0011_1100;
        a_data = 8'hA5;
        a_valid = 1'b1;
        tick();
        a_data = 8'h3C;
        for (int c = 1; c <= 16; c++) begin
            if (c == 9) a_valid = 1'b0;
            #1;
            checks++;
            if ({a_sv, a_sd, a_sf, a_sl, a_ready} !==
                {1'b1, exp_bits[16-c], (c == 1 || c == 9),
                 (c == 8 || c == 16), (c == 8 || c == 16)}) begin
                errors++;
                $display("FAIL b2b_c%0d got v/d/f/l/r %b want %b", c,
                         {a_sv, a_sd, a_sf, a_sl, a_ready},
                         {1'b1, exp_bits[16-c], (c == 1 || c == 9),
                          (c == 8 || c == 16), (c == 8 || c == 16)});
            end
            tick();
        end
        checks++;
        if ({a_sv, a_busy} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_end got v/b %b want 00", {a_sv, a_busy});
        end
    endtask

    // in_data churns during SHIFT; captured word 0x5A must be sent.
    task automatic test_data_hold();
        logic [7:0] exp_bits;
        exp_bits = 8'b0101_1010;
        a_data = 8'h5A;
        a_valid = 1'b1;
        tick();
        for (int c = 1; c <= 8; c++) begin
            a_data = 8'(c * 37 + 11);
            if (c == 8) a_valid = 1'b0;
            #1;
            checks++;
            if ({a_sv, a_sd, a_ready} !== {1'b1, exp_bits[8-c], (c == 8)}) begin
                errors++;
                $display("FAIL hold_c%0d got v/d/r %b want %b", c,
                         {a_sv, a_sd, a_ready}, {1'b1, exp_bits[8-c], (c == 8)});
            end
            tick();
        end
        checks++;
        if ({a_sv, a_ready} !== 2'b01) begin
            errors++;
            $display("FAIL hold_end got v/r %b want 01", {a_sv, a_ready});
        end
    endtask

    // LSB-first 0x01 at CLK_DIV=4: data 1 on cycles 1-4 only.
    task automatic test_clk_div_lsb();
        b_data = 8'h01;
        b_valid = 1'b1;
        tick();
        b_valid = 1'b0;
        b_data = 8'hFE;
        for (int c = 1; c <= 32; c++) begin
            checks++;
            if ({b_sv, b_sd, b_sf, b_sl, b_ready} !==
                {1'b1, (c <= 4), (c <= 4), (c >= 29), (c == 32)}) begin
                errors++;
                $display("FAIL div_c%0d got v/d/f/l/r %b want %b", c,
                         {b_sv, b_sd, b_sf, b_sl, b_ready},
                         {1'b1, (c <= 4), (c <= 4), (c >= 29), (c == 32)});
            end
            tick();
        end
        checks++;
        if ({b_sv, b_busy, b_ready} !== 3'b001) begin
            errors++;
            $display("FAIL div_end got v/b/r %b want 001", {b_sv, b_busy, b_ready});
        end
    endtask

    // GAP_BITS=2, CLK_DIV=2: 16 bit cycles, 4 gap cycles, IDLE at 21.
    task automatic test_gap();
        logic [7:0] w;
        w = 8'hC3;
        c_data = w;
        c_valid = 1'b1;
        tick();
        for (int c = 1; c <= 20; c++) begin
            checks++;
            if (c <= 16) begin
                if ({c_sv, c_busy, c_ready, c_sd} !==
                    {1'b1, 1'b1, 1'b0, w[7-(c-1)/2]}) begin
                    errors++;
                    $display("FAIL gap_shift_c%0d got v/b/r/d %b want %b", c,
                             {c_sv, c_busy, c_ready, c_sd},
                             {1'b1, 1'b1, 1'b0, w[7-(c-1)/2]});
                end
            end else begin
                if ({c_sv, c_busy, c_ready, c_sd} !== 4'b0100) begin
                    errors++;
                    $display("FAIL gap_idle_c%0d got v/b/r/d %b want 0100", c,
                             {c_sv, c_busy, c_ready, c_sd});
                end
            end
            tick();
        end
        c_data = 8'h80;
        #1;
        checks++;
        if ({c_ready, c_busy, c_sv} !== 3'b100) begin
            errors++;
            $display("FAIL gap_c21 got r/b/v %b want 100", {c_ready, c_busy, c_sv});
        end
        tick();
        c_valid = 1'b0;
        checks++;
        if ({c_sv, c_sf, c_sd} !== 3'b111) begin
            errors++;
            $display("FAIL gap_c22 got v/f/d %b want 111", {c_sv, c_sf, c_sd});
        end
        for (int i = 0; i < 24; i++) tick();
        checks++;
        if ({c_busy, c_ready} !== 2'b01) begin
            errors++;
            $display("FAIL gap_drain got b/r %b want 01", {c_busy, c_ready});
        end
    endtask

    // Reset during bit 3 aborts the word; 0xFF then sends cleanly.
    task automatic test_reset_mid_word();
        a_data = 8'h0F;
        a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        for (int c = 1; c <= 3; c++) tick();
        rst = 1'b1;
        #1;
        checks++;
        if ({a_sv, a_ready} !== 2'b10) begin
            errors++;
            $display("FAIL rstmid_c4 got v/r %b want 10", {a_sv, a_ready});
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if ({a_sd, a_sv, a_sf, a_sl, a_busy} !== 5'b0) begin
            errors++;
            $display("FAIL rstmid_outs got %b want 00000", {a_sd, a_sv, a_sf, a_sl, a_busy});
        end
        checks++;
        if (a_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_ready got %b want 1", a_ready);
        end
        a_data = 8'hFF;
        a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            checks++;
            if ({a_sv, a_sd, a_sf, a_sl} !== {1'b1, 1'b1, (c == 1), (c == 8)}) begin
                errors++;
                $display("FAIL rstmid_ff_c%0d got v/d/f/l %b want %b", c,
                         {a_sv, a_sd, a_sf, a_sl}, {1'b1, 1'b1, (c == 1), (c == 8)});
            end
            tick();
        end
        checks++;
        if ({a_sv, a_busy, a_ready} !== 3'b001) begin
            errors++;
            $display("FAIL rstmid_end got v/b/r %b want 001", {a_sv, a_busy, a_ready});
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_single_word();
        tick();
        test_back_to_back();
        tick();
        test_data_hold();
        tick();
        test_clk_div_lsb();
        tick();
        test_gap();
        tick();
        test_reset_mid_word();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
